// File: rtl/pong_ball_engine.sv
// =============================================================================
// Module  : pong_ball_engine
// Desc    : Pong ball physics: per-frame move, wall/paddle collision, lives and
//           game-over keeping. Define PONG_SPEEDUP_EN to enable the speed ramp.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module pong_ball_engine #(
  parameter int POS_W         = 10,
  parameter int FIELD_W       = 640,
  parameter int FIELD_H       = 480,
  parameter int BALL_SZ       = 8,
  parameter int PAD_X         = 16,
  parameter int PAD_W         = 8,
  parameter int PAD_H         = 64,
  parameter int LIVES         = 3,
  parameter int SPEED_MIN     = 1,
  parameter int SPEED_MAX     = 8,
  parameter int HITS_PER_STEP = 4
) (
  input  logic             Clk_100MHz,
  input  logic             Reset_n,
  input  logic             GameEnable,
  input  logic             ballPosReset,
  input  logic             LivesCountReset,
  input  logic [POS_W-1:0] paddlePosY,
  output logic [POS_W-1:0] ballPosX,
  output logic [POS_W-1:0] ballPosY,
  output logic [3:0]       ballSpeed,
  output logic [2:0]       LivesCount,
  output logic [2:0]       ColOut,
  output logic             GameOver,
  output logic             Busy
);

  // Two guard bits so a candidate position can go negative or past the field.
  localparam int CW = POS_W + 2;

  localparam logic signed [CW-1:0] c_xMax     = CW'(FIELD_W - BALL_SZ);
  localparam logic signed [CW-1:0] c_yMax     = CW'(FIELD_H - BALL_SZ);
  localparam logic signed [CW-1:0] c_padX     = CW'(PAD_X);
  localparam logic signed [CW-1:0] c_padRight = CW'(PAD_X + PAD_W);
  localparam logic signed [CW-1:0] c_padH     = CW'(PAD_H);
  localparam logic signed [CW-1:0] c_ballSz   = CW'(BALL_SZ);
  localparam logic [POS_W-1:0]     c_xCentre  = POS_W'((FIELD_W - BALL_SZ) / 2);
  localparam logic [POS_W-1:0]     c_yCentre  = POS_W'((FIELD_H - BALL_SZ) / 2);
  localparam logic [3:0]           c_speedMin = 4'(SPEED_MIN);
  localparam logic [2:0]           c_lives    = 3'(LIVES);

  if (LIVES < 1 || LIVES > 7 || SPEED_MIN < 1 || SPEED_MAX > 15 ||
      SPEED_MIN > SPEED_MAX || HITS_PER_STEP < 1 || HITS_PER_STEP > 15) begin : g_badParams
    $error("pong_ball_engine: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOVE    = 3'd1,
    S_CHECK   = 3'd2,
    S_RESPAWN = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [POS_W-1:0]     r_posX;
  logic [POS_W-1:0]     r_posY;
  logic                 r_dx;
  logic                 r_dy;
  logic [3:0]           r_speed;
  logic [2:0]           r_lives;
  logic [2:0]           r_col;
  logic                 r_gameOver;
  logic signed [CW-1:0] r_candX;
  logic signed [CW-1:0] r_candY;
`ifdef PONG_SPEEDUP_EN
  logic [3:0]           r_hits;
`endif

  logic signed [CW-1:0] w_xExt;
  logic signed [CW-1:0] w_yExt;
  logic signed [CW-1:0] w_spdExt;
  logic signed [CW-1:0] w_padTop;
  logic signed [CW-1:0] w_padBot;
  logic                 w_hitPad;
  logic                 w_miss;
  logic                 w_wallR;
  logic                 w_wallT;
  logic                 w_wallB;
  logic [2:0]           w_col;
  logic [POS_W-1:0]     w_newX;
  logic [POS_W-1:0]     w_newY;
  logic                 w_newDx;
  logic                 w_newDy;
  logic                 w_enterOver;
  logic                 w_ballReset;

  assign w_xExt   = $signed({2'b00, r_posX});
  assign w_yExt   = $signed({2'b00, r_posY});
  assign w_spdExt = $signed({{(CW-4){1'b0}}, r_speed});
  assign w_padTop = $signed({2'b00, paddlePosY});
  assign w_padBot = w_padTop + c_padH;

  // Paddle only catches a ball travelling left; it outranks the miss test.
  assign w_hitPad = !r_dx && (r_candX <= c_padRight) && ((r_candX + c_ballSz) > c_padX) &&
                    ((r_candY + c_ballSz) > w_padTop) && (r_candY < w_padBot);
  assign w_miss   = !w_hitPad && r_candX[CW-1];
  assign w_wallR  = r_candX > c_xMax;
  assign w_wallT  = r_candY[CW-1];
  assign w_wallB  = r_candY > c_yMax;

  // A ball leaving RESPAWN with no lives parks in OVER even if ballPosReset is up.
  assign w_enterOver = (r_state == S_RESPAWN) && (r_lives == 3'd0) && !LivesCountReset;
  assign w_ballReset = ballPosReset && ((r_state != S_OVER) || LivesCountReset);

  always_comb begin
    w_col   = 3'd0;
    w_newX  = r_candX[POS_W-1:0];
    w_newY  = r_candY[POS_W-1:0];
    w_newDx = r_dx;
    w_newDy = r_dy;
    if (w_wallT) begin
      w_newY  = '0;
      w_newDy = 1'b1;
    end else if (w_wallB) begin
      w_newY  = c_yMax[POS_W-1:0];
      w_newDy = 1'b0;
    end
    if (w_hitPad) begin
      w_newX  = c_padRight[POS_W-1:0];
      w_newDx = 1'b1;
      w_col   = 3'd3;
    end else if (w_miss) begin
      w_col   = 3'd4;
    end else if (w_wallR) begin
      w_newX  = c_xMax[POS_W-1:0];
      w_newDx = 1'b0;
      w_col   = 3'd2;
    end else if (w_wallT || w_wallB) begin
      w_col   = 3'd1;
    end
  end

  always_ff @(posedge Clk_100MHz or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (GameEnable && !r_gameOver) w_nextState = S_MOVE;
      S_MOVE:    w_nextState = S_CHECK;
      S_CHECK:   w_nextState = w_miss ? S_RESPAWN : S_IDLE;
      S_RESPAWN: w_nextState = w_enterOver ? S_OVER : S_IDLE;
      S_OVER:    if (LivesCountReset) w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
    if (w_ballReset && !w_enterOver) w_nextState = S_IDLE;
  end

  always_ff @(posedge Clk_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      r_posX     <= c_xCentre;
      r_posY     <= c_yCentre;
      r_dx       <= 1'b1;
      r_dy       <= 1'b1;
      r_speed    <= c_speedMin;
      r_lives    <= c_lives;
      r_col      <= 3'd0;
      r_gameOver <= 1'b0;
      r_candX    <= '0;
      r_candY    <= '0;
`ifdef PONG_SPEEDUP_EN
      r_hits     <= 4'd0;
`endif
    end else begin
      if (w_ballReset) begin
        r_posX  <= c_xCentre;
        r_posY  <= c_yCentre;
        r_speed <= c_speedMin;
`ifdef PONG_SPEEDUP_EN
        r_hits  <= 4'd0;
`endif
      end else begin
        case (r_state)
          S_MOVE: begin
            r_candX <= r_dx ? (w_xExt + w_spdExt) : (w_xExt - w_spdExt);
            r_candY <= r_dy ? (w_yExt + w_spdExt) : (w_yExt - w_spdExt);
          end
          S_CHECK: begin
            r_col <= w_col;
            if (w_miss) begin
              if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
            end else begin
              r_posX <= w_newX;
              r_posY <= w_newY;
              r_dx   <= w_newDx;
              r_dy   <= w_newDy;
`ifdef PONG_SPEEDUP_EN
              if (w_hitPad) begin
                if (r_hits == 4'(HITS_PER_STEP - 1)) begin
                  r_hits <= 4'd0;
                  if (r_speed < 4'(SPEED_MAX)) r_speed <= r_speed + 4'd1;
                end else begin
                  r_hits <= r_hits + 4'd1;
                end
              end
`endif
            end
          end
          S_RESPAWN: begin
            r_posX  <= c_xCentre;
            r_posY  <= c_yCentre;
            r_speed <= c_speedMin;
            r_dx    <= 1'b1;
`ifdef PONG_SPEEDUP_EN
            r_hits  <= 4'd0;
`endif
          end
          default: ;
        endcase
      end
      if (w_enterOver) r_gameOver <= 1'b1;
      if (LivesCountReset) begin
        r_lives    <= c_lives;
        r_gameOver <= 1'b0;
      end
    end
  end

  assign ballPosX   = r_posX;
  assign ballPosY   = r_posY;
  assign ballSpeed  = r_speed;
  assign LivesCount = r_lives;
  assign ColOut     = r_col;
  assign GameOver   = r_gameOver;
  assign Busy       = (r_state == S_MOVE) || (r_state == S_CHECK) || (r_state == S_RESPAWN);

endmodule

`default_nettype wire

// File: tb/tb_pong_ball_engine.sv
// =============================================================================
// Module  : tb_pong_ball_engine
// Desc    : Self-checking bench for pong_ball_engine: frame-level ball model
//           compared every cycle, plus hand-computed trajectory checkpoints.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pong_ball_engine;

  localparam int FIELD_W       = 640;
  localparam int FIELD_H       = 480;
  localparam int BALL_SZ       = 8;
  localparam int PAD_X         = 16;
  localparam int PAD_W         = 8;
  localparam int PAD_H         = 64;
  localparam int LIVES         = 3;
  localparam int SPEED_MIN     = 1;
  localparam int SPEED_MAX     = 8;
  localparam int HITS_PER_STEP = 4;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       GameEnable;
  logic       ballPosReset;
  logic       LivesCountReset;
  logic [9:0] paddlePosY;
  logic [9:0] ballPosX;
  logic [9:0] ballPosY;
  logic [3:0] ballSpeed;
  logic [2:0] LivesCount;
  logic [2:0] ColOut;
  logic       GameOver;
  logic       Busy;

  pong_ball_engine dut (
    .Clk_100MHz     (clk),
    .Reset_n        (Reset_n),
    .GameEnable     (GameEnable),
    .ballPosReset   (ballPosReset),
    .LivesCountReset(LivesCountReset),
    .paddlePosY     (paddlePosY),
    .ballPosX       (ballPosX),
    .ballPosY       (ballPosY),
    .ballSpeed      (ballSpeed),
    .LivesCount     (LivesCount),
    .ColOut         (ColOut),
    .GameOver       (GameOver),
    .Busy           (Busy)
  );

  always #5 clk = ~clk;

  int nErr    = 0;
  int nChecks = 0;
  bit cmpEn   = 1'b0;

  // Frame-level model of the ball, updated at negedges to describe the DUT
  // state expected after the following posedge.
  int mX, mY, mSpd, mLives, mCol;
  bit mDx, mDy, mOver, mBusy;
`ifdef PONG_SPEEDUP_EN
  int mHits;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic modelCentre();
    mX   = (FIELD_W - BALL_SZ) / 2;
    mY   = (FIELD_H - BALL_SZ) / 2;
    mSpd = SPEED_MIN;
`ifdef PONG_SPEEDUP_EN
    mHits = 0;
`endif
  endtask

  task automatic modelReset();
    modelCentre();
    mDx = 1'b1; mDy = 1'b1; mLives = LIVES; mCol = 0; mOver = 1'b0; mBusy = 1'b0;
  endtask

  task automatic modelStep(output bit miss);
    int nx, ny;
    bit pad, wy;
    nx  = mDx ? mX + mSpd : mX - mSpd;
    ny  = mDy ? mY + mSpd : mY - mSpd;
    pad = !mDx && nx <= PAD_X + PAD_W && nx + BALL_SZ > PAD_X &&
          ny + BALL_SZ > int'(paddlePosY) && ny < int'(paddlePosY) + PAD_H;
    miss = !pad && nx < 0;
    if (miss) begin
      mCol = 4;
      if (mLives > 0) mLives--;
      mBusy = 1'b1;
      return;
    end
    wy = 1'b0;
    if (ny < 0) begin
      ny = 0; mDy = 1'b1; wy = 1'b1;
    end else if (ny > FIELD_H - BALL_SZ) begin
      ny = FIELD_H - BALL_SZ; mDy = 1'b0; wy = 1'b1;
    end
    if (pad) begin
      nx = PAD_X + PAD_W; mDx = 1'b1; mCol = 3;
`ifdef PONG_SPEEDUP_EN
      mHits++;
      if (mHits == HITS_PER_STEP) begin
        mHits = 0;
        if (mSpd < SPEED_MAX) mSpd++;
      end
`endif
    end else if (nx > FIELD_W - BALL_SZ) begin
      nx = FIELD_W - BALL_SZ; mDx = 1'b0; mCol = 2;
    end else begin
      mCol = wy ? 1 : 0;
    end
    mX = nx; mY = ny; mBusy = 1'b0;
  endtask

  // Called at a negedge, returns at a negedge with the DUT idle again.
  task automatic frame(input bit dupGE);
    bit miss;
    GameEnable = 1'b1;
    if (mOver) begin
      @(negedge clk);
      GameEnable = 1'b0;
      return;
    end
    mBusy = 1'b1;
    @(negedge clk);
    GameEnable = dupGE;
    @(negedge clk);
    GameEnable = 1'b0;
    modelStep(miss);
    @(negedge clk);
    if (miss) begin
      modelCentre();
      mDx   = 1'b1;
      mBusy = 1'b0;
      mOver = (mLives == 0);
      @(negedge clk);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cmpEn) begin
      chk("cmp ballPosX",   32'(ballPosX),   32'(mX));
      chk("cmp ballPosY",   32'(ballPosY),   32'(mY));
      chk("cmp ballSpeed",  32'(ballSpeed),  32'(mSpd));
      chk("cmp LivesCount", 32'(LivesCount), 32'(mLives));
      chk("cmp ColOut",     32'(ColOut),     32'(mCol));
      chk("cmp GameOver",   32'(GameOver),   32'(mOver));
      chk("cmp Busy",       32'(Busy),       32'(mBusy));
    end
  end

  initial begin
    Reset_n = 1'b0; GameEnable = 1'b0; ballPosReset = 1'b0; LivesCountReset = 1'b0;
    paddlePosY = 10'd400;
    modelReset();
    @(negedge clk);
    cmpEn = 1'b1;
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    chk("reset X", 32'(ballPosX), 316);
    chk("reset Y", 32'(ballPosY), 236);
    chk("reset speed", 32'(ballSpeed), 1);
    chk("reset lives", 32'(LivesCount), 3);
    chk("reset col", 32'(ColOut), 0);
    chk("reset over", 32'(GameOver), 0);

    // Second GameEnable pulse while busy must not add a second step.
    frame(1'b1);
    chk("single step X", 32'(ballPosX), 317);
    chk("single step Y", 32'(ballPosY), 237);

    repeat (236) frame(1'b0);
    chk("bottom wall Y", 32'(ballPosY), 472);
    chk("bottom wall col", 32'(ColOut), 1);
    chk("bottom wall X", 32'(ballPosX), 553);

    repeat (80) frame(1'b0);
    chk("right wall X", 32'(ballPosX), 632);
    chk("right wall col", 32'(ColOut), 2);
    chk("right wall Y", 32'(ballPosY), 392);

    repeat (393) frame(1'b0);
    chk("top wall Y", 32'(ballPosY), 0);
    chk("top wall col", 32'(ColOut), 1);
    chk("top wall X", 32'(ballPosX), 239);

    paddlePosY = 10'd200;
    repeat (215) frame(1'b0);
    chk("paddle X", 32'(ballPosX), 24);
    chk("paddle Y", 32'(ballPosY), 215);
    chk("paddle col", 32'(ColOut), 3);

    // ballPosReset while in MOVE aborts the update and recentres.
    paddlePosY = 10'd400;
    GameEnable = 1'b1; mBusy = 1'b1;
    @(negedge clk);
    GameEnable = 1'b0; ballPosReset = 1'b1;
    modelCentre(); mBusy = 1'b0;
    @(negedge clk);
    ballPosReset = 1'b0;
    chk("ballPosReset X", 32'(ballPosX), 316);
    chk("ballPosReset busy", 32'(Busy), 0);
    chk("ballPosReset col held", 32'(ColOut), 3);

    repeat (950) frame(1'b0);
    chk("miss1 col", 32'(ColOut), 4);
    chk("miss1 lives", 32'(LivesCount), 2);
    chk("miss1 X", 32'(ballPosX), 316);
    chk("miss1 Y", 32'(ballPosY), 236);

    repeat (950) frame(1'b0);
    chk("miss2 lives", 32'(LivesCount), 1);
    repeat (950) frame(1'b0);
    chk("miss3 lives", 32'(LivesCount), 0);
    chk("miss3 over", 32'(GameOver), 1);

    frame(1'b0);
    frame(1'b0);
    chk("over ignore X", 32'(ballPosX), 316);
    chk("over ignore busy", 32'(Busy), 0);

    LivesCountReset = 1'b1; mLives = LIVES; mOver = 1'b0;
    @(negedge clk);
    LivesCountReset = 1'b0;
    chk("lives reset lives", 32'(LivesCount), 3);
    chk("lives reset over", 32'(GameOver), 0);

    // Reset_n asserted while the update sits in CHECK.
    GameEnable = 1'b1; mBusy = 1'b1;
    @(negedge clk);
    GameEnable = 1'b0;
    @(negedge clk);
    Reset_n = 1'b0;
    modelReset();
    #1;
    chk("async reset X", 32'(ballPosX), 316);
    chk("async reset col", 32'(ColOut), 0);
    chk("async reset busy", 32'(Busy), 0);
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    frame(1'b0);
    chk("post reset X", 32'(ballPosX), 317);
    chk("post reset Y", 32'(ballPosY), 237);

    cmpEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
